// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the MIPS hazard logic: register
// specifier width, forwarding-select encodings and the in-flight slot record.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  regwrite;
        logic                  isload;
    } slot_t;

    // A slot supplies a value for a source register only if it really writes it.
    function automatic logic fwdMatch(input slot_t s, input logic uses,
                                      input logic [REG_ADDR_W-1:0] src);
        return s.valid && s.regwrite && uses && (s.dest == src);
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline-stage record of an in-flight destination register;
// a bubble or reset clears every field.
module hazard_slot
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  bubble,
    input  slot_t nextSlot,
    output slot_t slot
);

    always_ff @(posedge clk) begin
        if (reset || bubble)
            slot <= '0;
        else
            slot <= nextSlot;
    end

endmodule

// File: rtl/reg_read_hazard_unit.sv
// Tracks destination registers through EX/MEM/WB and produces operand
// forwarding selects, the load-use stall, ID write-through bypass and the WB port.
module reg_read_hazard_unit
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IdValid,
    input  logic [REG_ADDR_W-1:0] IdRs,
    input  logic [REG_ADDR_W-1:0] IdRt,
    input  logic                  IdUsesRs,
    input  logic                  IdUsesRt,
    input  logic [REG_ADDR_W-1:0] IdWriteReg,
    input  logic                  IdRegWrite,
    input  logic                  IdMemRead,
    input  logic                  Flush,
    output logic                  Stall,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  IdBypassA,
    output logic                  IdBypassB,
    output logic [REG_ADDR_W-1:0] WbWriteReg,
    output logic                  WbRegWrite
);

    slot_t idSlot;
    slot_t exSlot;
    slot_t memSlot;
    slot_t wbSlot;
    logic  exBubble;

    logic [REG_ADDR_W-1:0] exRs;
    logic [REG_ADDR_W-1:0] exRt;
    logic                  exUsesRs;
    logic                  exUsesRt;

    logic unusedSlotBits;

    // Writes to $0 are dropped on entry so later compares never see them.
    always_comb begin
        idSlot          = '0;
        idSlot.valid    = 1'b1;
        idSlot.dest     = IdWriteReg;
        idSlot.regwrite = IdRegWrite && (IdWriteReg != ZERO_REG);
        idSlot.isload   = IdMemRead;
    end

    assign exBubble = Stall || Flush || !IdValid;

    hazard_slot exStage (
        .clk      (clk),
        .reset    (reset),
        .bubble   (exBubble),
        .nextSlot (idSlot),
        .slot     (exSlot)
    );

    hazard_slot memStage (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .nextSlot (exSlot),
        .slot     (memSlot)
    );

    hazard_slot wbStage (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .nextSlot (memSlot),
        .slot     (wbSlot)
    );

    // Source operands of the EX instruction, cleared together with its slot.
    always_ff @(posedge clk) begin
        if (reset || exBubble) begin
            exRs     <= '0;
            exRt     <= '0;
            exUsesRs <= 1'b0;
            exUsesRt <= 1'b0;
        end else begin
            exRs     <= IdRs;
            exRt     <= IdRt;
            exUsesRs <= IdUsesRs;
            exUsesRt <= IdUsesRt;
        end
    end

    assign Stall = IdValid && exSlot.valid && exSlot.isload && (exSlot.dest != ZERO_REG) &&
                   ((IdUsesRs && (IdRs == exSlot.dest)) || (IdUsesRt && (IdRt == exSlot.dest)));

    // MEM holds the youngest producer, so it wins over WB.
    always_comb begin
        ForwardA = FWD_REGFILE;
        if (fwdMatch(memSlot, exUsesRs, exRs))
            ForwardA = FWD_MEM;
        else if (fwdMatch(wbSlot, exUsesRs, exRs))
            ForwardA = FWD_WB;

        ForwardB = FWD_REGFILE;
        if (fwdMatch(memSlot, exUsesRt, exRt))
            ForwardB = FWD_MEM;
        else if (fwdMatch(wbSlot, exUsesRt, exRt))
            ForwardB = FWD_WB;
    end

    assign IdBypassA  = fwdMatch(wbSlot, IdUsesRs, IdRs);
    assign IdBypassB  = fwdMatch(wbSlot, IdUsesRt, IdRt);
    assign WbRegWrite = wbSlot.valid && wbSlot.regwrite;
    assign WbWriteReg = WbRegWrite ? wbSlot.dest : ZERO_REG;

    assign unusedSlotBits = ^{exSlot.regwrite, memSlot.isload, wbSlot.isload};

endmodule
